// File: rtl/text_pkg.sv
// Shared definitions for the text writer: grid defaults, control-code
// constants, the writer FSM state encoding and the cursor command set.
// No ports; imported by the interface, the cursor sub-module and the top.
package text_pkg;

  // Grid defaults: 640x480 visible area with 16x16 pixel cells.
  localparam int DEF_COLS     = 40;
  localparam int DEF_ROWS     = 30;
  localparam int DEF_COL_BITS = 6;
  localparam int DEF_ROW_BITS = 5;
  localparam int DEF_TAB      = 8;

  // Control codes and printable range.
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Commands understood by grid_cursor; one per cycle.
  typedef enum logic [2:0] {
    CUR_NONE    = 3'd0,
    CUR_HOME    = 3'd1,
    CUR_ADVANCE = 3'd2,
    CUR_NEWLINE = 3'd3,
    CUR_CR      = 3'd4,
    CUR_TAB     = 3'd5,
    CUR_BS      = 3'd6
  } cur_cmd_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_SPACE) && (b <= CH_TILDE);
  endfunction

endpackage

// File: rtl/text_writer_if.sv
// Bus bundle of the text writer: the incoming byte stream and the character
// RAM write port.
//   in_data/in_valid/in_ready : byte stream into the writer
//   wr_en/wr_addr/wr_data     : single-cycle RAM writes, wr_addr = {row, col}
// Handshake: a byte transfers on a rising clock edge where in_valid and
// in_ready are both high; in_data is only looked at on that edge, a source
// holds in_data stable while in_valid is high and unaccepted, and in_ready
// never depends on in_valid.
// Modports: master = byte source / RAM side, slave = the text writer.
interface text_writer_if
  import text_pkg::*;
#(
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int ROW_BITS = DEF_ROW_BITS
);

  logic [7:0]                   in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic                         wr_en;
  logic [ROW_BITS+COL_BITS-1:0] wr_addr;
  logic [7:0]                   wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/grid_cursor.sv
// Row/column position register over the COLS x ROWS grid. Applies one cursor
// command per cycle with the grid wrap rules (no scrolling: the row wraps to
// 0). Used both as the text cursor and as the clear sweep counter.
// Ports:
//   clk, rst : clock, synchronous active-high reset (position -> (0,0))
//   cmd_i    : command for this cycle
//   col_o    : current column
//   row_o    : current row
module grid_cursor
  import text_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int TAB      = DEF_TAB
) (
  input  logic                clk,
  input  logic                rst,
  input  cur_cmd_e            cmd_i,
  output logic [COL_BITS-1:0] col_o,
  output logic [ROW_BITS-1:0] row_o
);

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS:0]   TAB_W    = (COL_BITS+1)'(TAB);
  localparam logic [COL_BITS:0]   TAB_MASK = ~((COL_BITS+1)'(TAB - 1));
  localparam logic [COL_BITS:0]   COLS_W   = (COL_BITS+1)'(COLS);

  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [ROW_BITS-1:0] row_inc;
  logic [COL_BITS:0]   tab_col;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    row_inc = (row_q == ROW_LAST) ? '0 : row_q + ROW_BITS'(1);
    // One spare bit so a tab stop past the last column cannot alias back
    // into the grid when COLS is close to 2^COL_BITS.
    tab_col = ({1'b0, col_q} + TAB_W) & TAB_MASK;
    case (cmd_i)
      CUR_HOME: begin
        col_d = '0;
        row_d = '0;
      end
      CUR_ADVANCE: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = col_q + COL_BITS'(1);
        end
      end
      CUR_NEWLINE: row_d = row_inc;
      CUR_CR:      col_d = '0;
      CUR_TAB: begin
        if (tab_col >= COLS_W) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = tab_col[COL_BITS-1:0];
        end
      end
      CUR_BS: begin
        if (col_q != '0) col_d = col_q - COL_BITS'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/text_writer.sv
// Text-buffer writer in front of the character RAM write port. Clears the
// grid to spaces after reset (and on form feed), then takes one byte per
// cycle, writing printable characters at the cursor and interpreting
// CR, LF, BS, TAB and FF as cursor/clear commands.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bus         : stream in + RAM write port (text_writer_if.slave)
//   cur_col     : current cursor column
//   cur_row     : current cursor row
//   busy        : clear sweep in progress
//   dbg_state_o : FSM state for observation
module text_writer
  import text_pkg::*;
#(
  parameter int COLS     = DEF_COLS,
  parameter int ROWS     = DEF_ROWS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int TAB      = DEF_TAB
) (
  input  logic                clk,
  input  logic                rst,
  text_writer_if.slave        bus,
  output logic [COL_BITS-1:0] cur_col,
  output logic [ROW_BITS-1:0] cur_row,
  output logic                busy,
  output state_e              dbg_state_o
);

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
  localparam int                  AW       = ROW_BITS + COL_BITS;

  state_e              state_q, state_d;
  cur_cmd_e            cur_cmd, swp_cmd;
  logic [COL_BITS-1:0] swp_col;
  logic [ROW_BITS-1:0] swp_row;
  logic                swp_end;
  logic [COL_BITS-1:0] col_m1;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;

  grid_cursor #(
    .COLS(COLS), .ROWS(ROWS), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .TAB(TAB)
  ) u_cursor (
    .clk(clk), .rst(rst), .cmd_i(cur_cmd), .col_o(cur_col), .row_o(cur_row)
  );

  // The sweep counter always rests at (0,0) outside a clear: advancing past
  // the last cell wraps it home, so a new clear can start writing at once.
  grid_cursor #(
    .COLS(COLS), .ROWS(ROWS), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .TAB(TAB)
  ) u_sweep (
    .clk(clk), .rst(rst), .cmd_i(swp_cmd), .col_o(swp_col), .row_o(swp_row)
  );

  assign swp_end = (swp_col == COL_LAST) && (swp_row == ROW_LAST);
  assign col_m1  = cur_col - COL_BITS'(1);

  always_comb begin
    state_d   = state_q;
    cur_cmd   = CUR_NONE;
    swp_cmd   = CUR_NONE;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {swp_row, swp_col};
        wr_data_d = CH_SPACE;
        swp_cmd   = CUR_ADVANCE;
        if (swp_end) begin
          state_d = ST_IDLE;
          cur_cmd = CUR_HOME;
        end
      end
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_printable(bus.in_data)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {cur_row, cur_col};
            wr_data_d = bus.in_data;
            cur_cmd   = CUR_ADVANCE;
          end else begin
            case (bus.in_data)
              CH_CR:  cur_cmd = CUR_CR;
              CH_LF:  cur_cmd = CUR_NEWLINE;
              CH_TAB: cur_cmd = CUR_TAB;
              CH_BS: begin
                if (cur_col != '0) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {cur_row, col_m1};
                  wr_data_d = CH_SPACE;
                  cur_cmd   = CUR_BS;
                end
              end
              CH_FF: begin
                // Cell (0,0) is written on the accept edge itself so the
                // sweep's first write lands in the very next cycle.
                state_d   = ST_CLEAR;
                wr_en_d   = 1'b1;
                wr_addr_d = {swp_row, swp_col};
                wr_data_d = CH_SPACE;
                swp_cmd   = CUR_ADVANCE;
                cur_cmd   = CUR_HOME;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= CH_SPACE;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q == ST_CLEAR);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: clear sweeps, a table of single-byte vectors,
// wrap/tab corner sequences and a form feed interrupted by reset.
module tb_text_writer;
  import text_pkg::*;

  localparam int COLS        = 40;
  localparam int ROWS        = 30;
  localparam int COL_BITS    = 6;
  localparam int ROW_BITS    = 5;
  localparam int REC_W       = ROW_BITS + COL_BITS + 8;
  localparam int CLEAR_CYC   = 1200;
  localparam int CYCLE_LIMIT = 5000;
  localparam int NV          = 18;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                rst;
  logic [COL_BITS-1:0] cur_col;
  logic [ROW_BITS-1:0] cur_row;
  logic                busy;
  state_e              dbg_state;

  always #5 clk = ~clk;

  text_writer_if bus ();

  text_writer dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int m_row    = 0;
  int m_col    = 0;

  typedef struct {
    logic [7:0] data;
    logic       exp_wr;
    int         wr_row;
    int         wr_col;
    logic [7:0] wr_data;
    int         exp_row;
    int         exp_col;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [REC_W-1:0] rec(input int row, input int col, input logic [7:0] d);
    logic [ROW_BITS-1:0] r;
    logic [COL_BITS-1:0] c;
    r = ROW_BITS'(row);
    c = COL_BITS'(col);
    return {r, c, d};
  endfunction

  // Advance one clock; sample the write port 1 ns after the edge and score it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        check("write", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic push_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back(rec(r, c, 8'h20));
  endtask

  // Counts cycles from now until in_ready rises; a clear must take 1200.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < CYCLE_LIMIT) begin
      tick();
      n++;
    end
    check(name, n, CLEAR_CYC);
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] b);
    int   n;
    logic took;
    n    = 0;
    took = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!took && n < CYCLE_LIMIT) begin
      took = (bus.in_ready === 1'b1);
      tick();
      n++;
    end
    if (!took) begin
      n_checks++;
      $display("FAIL send_timeout: byte 0x%0h not accepted", b);
    end
    bus.in_valid = 1'b0;
  endtask

  // Reference cursor for positioning runs (printables and LF only).
  task automatic model_send(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(rec(m_row, m_col, b));
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    end
    send(b);
  endtask

  // ---------------- test ----------------
  initial begin
    int base;
    int n;

    //          data   wr    row col wdata  erow ecol
    vecs[0]  = '{8'h48, 1'b1, 0, 0, 8'h48, 0, 1};
    vecs[1]  = '{8'h69, 1'b1, 0, 1, 8'h69, 0, 2};
    vecs[2]  = '{8'h0A, 1'b0, 0, 0, 8'h00, 1, 2};
    vecs[3]  = '{8'h0A, 1'b0, 0, 0, 8'h00, 2, 2};
    vecs[4]  = '{8'h0A, 1'b0, 0, 0, 8'h00, 3, 2};
    vecs[5]  = '{8'h61, 1'b1, 3, 2, 8'h61, 3, 3};
    vecs[6]  = '{8'h62, 1'b1, 3, 3, 8'h62, 3, 4};
    vecs[7]  = '{8'h63, 1'b1, 3, 4, 8'h63, 3, 5};
    vecs[8]  = '{8'h08, 1'b1, 3, 4, 8'h20, 3, 4};
    vecs[9]  = '{8'h09, 1'b0, 0, 0, 8'h00, 3, 8};
    vecs[10] = '{8'h0D, 1'b0, 0, 0, 8'h00, 3, 0};
    vecs[11] = '{8'h0A, 1'b0, 0, 0, 8'h00, 4, 0};
    vecs[12] = '{8'h08, 1'b0, 0, 0, 8'h00, 4, 0};
    vecs[13] = '{8'h07, 1'b0, 0, 0, 8'h00, 4, 0};
    vecs[14] = '{8'h7E, 1'b1, 4, 0, 8'h7E, 4, 1};
    vecs[15] = '{8'h7F, 1'b0, 0, 0, 8'h00, 4, 1};
    vecs[16] = '{8'h1F, 1'b0, 0, 0, 8'h00, 4, 1};
    vecs[17] = '{8'h20, 1'b1, 4, 1, 8'h20, 4, 2};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    repeat (3) tick();

    check("rst in_ready", bus.in_ready, 0);
    check("rst wr_en",    bus.wr_en,    0);
    check("rst wr_addr",  bus.wr_addr,  0);
    check("rst wr_data",  bus.wr_data,  8'h20);
    check("rst cur_col",  cur_col,      0);
    check("rst cur_row",  cur_row,      0);
    check("rst busy",     busy,         1);
    check("rst state",    dbg_state,    ST_CLEAR);

    // Power-up clear: 1200 space writes in raster order, then idle at (0,0).
    push_clear();
    rst = 1'b0;
    wait_ready("reset_to_ready_cycles");
    check("clear writes outstanding", exp_q.size(), 0);
    check("idle busy",    busy,    0);
    check("idle cur_col", cur_col, 0);
    check("idle cur_row", cur_row, 0);

    // Table vectors, sent back-to-back.
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].exp_wr) exp_q.push_back(rec(vecs[i].wr_row, vecs[i].wr_col, vecs[i].wr_data));
      send(vecs[i].data);
      check($sformatf("vec%0d cur_col", i), cur_col, vecs[i].exp_col);
      check($sformatf("vec%0d cur_row", i), cur_row, vecs[i].exp_row);
    end
    m_row = vecs[NV-1].exp_row;
    m_col = vecs[NV-1].exp_col;

    // Move to (2,37): LF wraps past the last row.
    repeat (28) model_send(8'h0A);
    repeat (35) model_send(8'h78);
    check("pos cur_col", cur_col, 37);
    check("pos cur_row", cur_row, 2);
    send(8'h09);
    check("tab_wrap cur_col", cur_col, 0);
    check("tab_wrap cur_row", cur_row, 3);
    send(8'h07);
    check("bel cur_col", cur_col, 0);
    check("bel cur_row", cur_row, 3);
    m_row = 3;
    m_col = 0;

    // Move to (29,39) and write the last cell: the cursor wraps home.
    repeat (26) model_send(8'h0A);
    repeat (39) model_send(8'h79);
    check("last cur_col", cur_col, 39);
    check("last cur_row", cur_row, 29);
    exp_q.push_back(rec(29, 39, 8'h41));
    send(8'h41);
    check("grid_wrap cur_col", cur_col, 0);
    check("grid_wrap cur_row", cur_row, 0);

    // Form feed with a byte held valid behind it, reset after 500 clears.
    push_clear();
    base = wr_cnt;
    check("ff in_ready before", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0C;
    tick();
    check("ff in_ready next cycle", bus.in_ready, 0);
    check("ff first wr_en",         bus.wr_en,    1);
    check("ff first wr_addr",       bus.wr_addr,  0);
    check("ff busy",                busy,         1);
    bus.in_data = 8'h51;
    n = 0;
    while (wr_cnt < base + 500 && n < CYCLE_LIMIT) begin
      tick();
      n++;
    end
    check("ff writes before reset", wr_cnt - base, 500);
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    check("midclear rst in_ready", bus.in_ready, 0);
    check("midclear rst wr_en",    bus.wr_en,    0);
    check("midclear rst busy",     busy,         1);
    rst = 1'b0;
    push_clear();
    exp_q.push_back(rec(0, 0, 8'h51));
    wait_ready("rst_midclear_to_ready_cycles");
    check("held byte pending cur_col", cur_col, 0);
    tick();
    bus.in_valid = 1'b0;
    check("held byte cur_col", cur_col, 1);
    check("held byte cur_row", cur_row, 0);
    tick();
    tick();
    check("expected writes outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
